// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one-word command port in, one-cycle response pulse out.
// Optional watchdog compiled in with `define AXIL_MASTER_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axi_lite_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] AWADDR,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
    } state_t;

    state_t state, state_nxt;
    logic   aw_done, w_done;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   cmd_hs, busy, timeout, to_fire;

    // Handshake outputs decode straight from state so a reset edge drops them at once.
    assign AWVALID   = (state == WR_REQ) && !aw_done;
    assign WVALID    = (state == WR_REQ) && !w_done;
    assign BREADY    = (state == WR_RESP);
    assign ARVALID   = (state == RD_REQ);
    assign RREADY    = (state == RD_RESP);
    assign rsp_valid = (state == DONE);
    assign cmd_ready = ARESETn && (state == IDLE);

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign cmd_hs = cmd_valid && cmd_ready;
    assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;

    // Saturating so a beat that lands on the limit edge cannot wrap the count.
    always_ff @(posedge ACLK) begin
        if (!ARESETn || !busy)
            to_cnt <= '0;
        else if (to_cnt != 16'hFFFF)
            to_cnt <= to_cnt + 16'd1;
    end

    assign timeout = busy && (to_cnt >= TO_LAST);
`else
    logic unused_to;
    assign unused_to = ^TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nxt = WR_RESP;
                else if (timeout)
                    state_nxt = DONE;
            end
            WR_RESP: if (b_hs || timeout) state_nxt = DONE;
            RD_REQ: begin
                if (ar_hs)
                    state_nxt = RD_RESP;
                else if (timeout)
                    state_nxt = DONE;
            end
            RD_RESP: if (r_hs || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A real beat on the limit edge wins over the watchdog.
    assign to_fire = timeout && (state_nxt == DONE) && !b_hs && !r_hs;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            AWADDR    <= '0;
            WDATA     <= '0;
            ARADDR    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            if (cmd_hs) begin
                if (cmd_write) begin
                    AWADDR <= cmd_addr;
                    WDATA  <= cmd_wdata;
                end else begin
                    ARADDR <= cmd_addr;
                end
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs) begin
                rsp_resp  <= BRESP;
                rsp_rdata <= '0;
            end
            if (r_hs) begin
                rsp_resp  <= RRESP;
                rsp_rdata <= RDATA;
            end
            if (to_fire) begin
                rsp_resp  <= 2'b10;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master
Single-outstanding AXI4-Lite initiator for the SRAM subsystem. Converts one-word read/write commands from a simple valid/ready command port into AXI4-Lite transactions. It drives any AXI4-Lite responder on the same bus, such as the SRAM slave. Each read or write completes with a one-cycle response pulse carrying read data and the response code.
## Interface
- TIMEOUT_CYCLES, 256: watchdog limit in cycles. Used only when the timeout feature is compiled in. Legal range 2..65535.
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; high only in IDLE and only while ARESETn is high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address, forwarded unmodified
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP as received; 2'b10 on timeout
- AWADDR  out  32  write address
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- WDATA  out  32  write data
- WVALID  out  1  write data valid
- WREADY  in  1  write data ready
- BRESP  in  2  write response
- BVALID  in  1  write response valid
- BREADY  out  1  write response ready
- ARADDR  out  32  read address
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- RDATA  in  32  read data
- RRESP  in  2  read response
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready
## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE. Reset state is IDLE.
- IDLE: a cmd_valid&&cmd_ready edge latches addr/wdata into AWADDR/WDATA (write) or ARADDR (read), then moves to WR_REQ or RD_REQ. cmd_valid in any other state is ignored and is not consumed.
- WR_REQ: AWVALID and WVALID both rise on entry. Each one drops independently on its own handshake edge (xVALID&&xREADY). Both handshakes may land on the same edge. Moves to WR_RESP once both are done.
- WR_RESP: BREADY=1. On the BVALID edge, capture BRESP, set rsp_rdata=0, move to DONE.
- RD_REQ: ARVALID=1 until the ARREADY edge, then RD_RESP.
- RD_RESP: RREADY=1. On the RVALID edge, capture RDATA/RRESP and move to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_resp hold their values until the next completion.
- xVALID signals never drop before their handshake. AWADDR/WDATA/ARADDR stay stable while their VALID is high.
## Timing
- Reset values: all VALID/READY outputs 0, rsp_valid 0, cmd_ready 0, all addr/data/resp registers 0.
- Reset mid-transaction: at the next edge with ARESETn low, return to IDLE and drop all VALIDs. No response is issued.
- Against an always-ready responder with 1-cycle B/R latency:
  - Write: cmd edge T, AW/W handshake T+1, B handshake T+2, rsp_valid during T+3.
  - Read: same cycle schedule as write.
- Back-to-back: cmd_ready rises the cycle after rsp_valid. Minimum command spacing is 4 cycles.
## Configuration
- AXIL_MASTER_TIMEOUT_EN defined: a 16-bit counter clears on leaving IDLE and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP. At count == TIMEOUT_CYCLES-1 the block:
  - drops all VALID/READY outputs on the next edge;
  - moves to DONE with rsp_resp=2'b10 and rsp_rdata=0.
  - Late B/R beats are not acknowledged.
- Not defined: no counter; the block waits indefinitely in any state.
## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10, against the SRAM slave. Required: write rsp_resp=0; read rsp_rdata=0xDEADBEEF, rsp_resp=0; rsp_valid 3 cycles after each cmd edge.
- AWREADY held low 5 cycles, WREADY immediate. Required: WVALID drops after 1 cycle; AWVALID and AWADDR stay stable for 5 cycles; exactly one response.
- BVALID with BRESP=2'b10, then RVALID with RRESP=2'b11 and RDATA=0x1234. Required: rsp_resp passes 2'b10 and 2'b11 through unchanged; rsp_rdata=0x1234.
- ARESETn low for 1 cycle while in RD_RESP. Required: next cycle ARVALID=RREADY=rsp_valid=0 and cmd_ready=0; cmd_ready=1 the cycle after reset releases.
- With the macro defined and TIMEOUT_CYCLES=8, a read where RVALID never rises. Required: RREADY drops and rsp_valid pulses with rsp_resp=2'b10, rsp_rdata=0 about 9 cycles after the cmd edge.
- cmd_valid held high for 3 write commands. Required: 3 responses, 4 cycles apart, each with rsp_resp=0.
